// File: rtl/rv_dmem_pipe.sv
// Data memory with valid/ready request and response channels, fixed read latency and an
// in-order response FIFO. Define RV_DMEM_ALIGN_CHK_EN to flag misaligned/illegal requests.
module rv_dmem_pipe #(
  parameter int unsigned MEM_SIZE_BYTES  = 1024,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wr_en_i,
  input  logic [31:0] req_wr_data_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic        req_is_signed_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rd_data_o,
  output logic        rsp_err_o
);

  localparam int unsigned Words = MEM_SIZE_BYTES / 4;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     mem_q [Words];
  logic            accept;
  logic            pop;
  logic            push;
  logic            in_range;
  logic [IdxW-1:0] word_idx;
  logic [31:0]     rd_word;
  logic [31:0]     lane_mask;
  logic [31:0]     fmt_data;
  logic [31:0]     rsp_data_in;
  logic            req_err;

  assign accept   = req_valid_i && req_ready_o;
  assign pop      = rsp_valid_o && rsp_ready_i;
  assign in_range = req_addr_i < 32'(MEM_SIZE_BYTES);
  assign word_idx = req_addr_i[IdxW+1:2];
  assign rd_word  = in_range ? mem_q[word_idx] : '0;

  assign lane_mask = {{8{req_byte_en_i[3]}}, {8{req_byte_en_i[2]}},
                      {8{req_byte_en_i[1]}}, {8{req_byte_en_i[0]}}};

  always_comb begin
    fmt_data = rd_word & lane_mask;
    case (req_byte_en_i)
      4'b0001: fmt_data = {{24{req_is_signed_i & rd_word[7]}},  rd_word[7:0]};
      4'b0010: fmt_data = {{24{req_is_signed_i & rd_word[15]}}, rd_word[15:8]};
      4'b0100: fmt_data = {{24{req_is_signed_i & rd_word[23]}}, rd_word[23:16]};
      4'b1000: fmt_data = {{24{req_is_signed_i & rd_word[31]}}, rd_word[31:24]};
      4'b0011: fmt_data = {{16{req_is_signed_i & rd_word[15]}}, rd_word[15:0]};
      4'b1100: fmt_data = {{16{req_is_signed_i & rd_word[31]}}, rd_word[31:16]};
      4'b1111: fmt_data = rd_word;
      default: fmt_data = rd_word & lane_mask;
    endcase
  end

`ifdef RV_DMEM_ALIGN_CHK_EN
  logic       be_legal;
  logic [1:0] low_lane;

  always_comb begin
    be_legal = req_byte_en_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                     4'b0011, 4'b1100, 4'b1111};
    if (req_byte_en_i[0])      low_lane = 2'd0;
    else if (req_byte_en_i[1]) low_lane = 2'd1;
    else if (req_byte_en_i[2]) low_lane = 2'd2;
    else                       low_lane = 2'd3;
  end

  assign req_err = !be_legal || (low_lane != req_addr_i[1:0]) || !in_range;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];
  assign req_err         = 1'b0;
`endif

  assign rsp_data_in = (req_wr_en_i || req_err) ? '0 : fmt_data;

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_wr_en_i && in_range && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_byte_en_i[b]) mem_q[word_idx][8*b +: 8] <= req_wr_data_i[8*b +: 8];
      end
    end
  end

  logic        pipe_vld_q  [RD_LATENCY];
  logic [31:0] pipe_data_q [RD_LATENCY];
  logic        pipe_err_q  [RD_LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_data_q[k] <= '0;
        pipe_err_q[k]  <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= accept;
      pipe_data_q[0] <= rsp_data_in;
      pipe_err_q[0]  <= req_err;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_data_q[k] <= pipe_data_q[k-1];
        pipe_err_q[k]  <= pipe_err_q[k-1];
      end
    end
  end

  assign push = pipe_vld_q[RD_LATENCY-1];

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outstanding count bounds pipe + FIFO occupancy, so the FIFO cannot overflow.
  logic [31:0]     fifo_data_q [MAX_OUTSTANDING];
  logic            fifo_err_q  [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    out_cnt_d = out_cnt_q;
    if (accept && !pop)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!accept && pop) out_cnt_d = out_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
        fifo_data_q[k] <= '0;
        fifo_err_q[k]  <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= pipe_data_q[RD_LATENCY-1];
        fifo_err_q[wr_ptr_q]  <= pipe_err_q[RD_LATENCY-1];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign req_ready_o   = out_cnt_q < CntW'(MAX_OUTSTANDING);
  assign rsp_valid_o   = fifo_cnt_q != '0;
  assign rsp_rd_data_o = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_err_o     = rsp_valid_o ? fifo_err_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_rv_dmem_pipe.sv
// Bench for rv_dmem_pipe: directed and random requests checked against a byte-array memory
// model and a queue of expected responses with due cycles.
module tb_rv_dmem_pipe;

  localparam int unsigned MemBytes = 1024;
  localparam int unsigned RdLat    = 2;
  localparam int unsigned MaxOut   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr_en, req_is_signed;
  logic [31:0] req_addr, req_wr_data;
  logic [3:0]  req_byte_en;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rd_data;

  rv_dmem_pipe #(
    .MEM_SIZE_BYTES (MemBytes),
    .RD_LATENCY     (RdLat),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_wr_en_i    (req_wr_en),
    .req_wr_data_i  (req_wr_data),
    .req_byte_en_i  (req_byte_en),
    .req_is_signed_i(req_is_signed),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rd_data_o  (rsp_rd_data),
    .rsp_err_o      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [MemBytes];
  int unsigned cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  legal_be [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: applies a request to the byte model and returns the response it must produce.
  function automatic exp_t model_req(logic wr, logic [31:0] addr, logic [31:0] wd,
                                     logic [3:0] be, logic sgn);
    exp_t        r;
    logic [31:0] word;
    int unsigned base, w, sh;
    longint      v;
    bit          inr;
    inr    = addr < MemBytes;
    base   = {addr[31:2], 2'b00};
    r.err  = 1'b0;
    r.data = '0;
    r.due  = 0;
`ifdef RV_DMEM_ALIGN_CHK_EN
    begin
      int lo;
      lo = 0;
      while (lo < 3 && !be[lo]) lo++;
      if (!(be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) || lo != int'(addr[1:0]) || !inr)
        r.err = 1'b1;
    end
`endif
    if (r.err) return r;
    if (wr) begin
      if (inr) for (int b = 0; b < 4; b++) if (be[b]) ref_mem[base+b] = wd[8*b +: 8];
      return r;
    end
    word = '0;
    if (inr) for (int b = 0; b < 4; b++) word[8*b +: 8] = ref_mem[base+b];
    if (be == 4'hF) begin
      r.data = word;
    end else if ($countones(be) == 1 || be == 4'h3 || be == 4'hC) begin
      w  = ($countones(be) == 1) ? 8 : 16;
      sh = (be == 4'hC) ? 16 : (be == 4'h3) ? 0 : 8 * $clog2(be);
      v  = (64'(word) >> sh) % (64'd1 << w);
      if (sgn && v >= (64'd1 << (w - 1))) v = v - (64'd1 << w);
      r.data = v[31:0];
    end else begin
      for (int b = 0; b < 4; b++) if (be[b]) r.data[8*b +: 8] = word[8*b +: 8];
    end
    return r;
  endfunction

  task automatic step(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic sg, input logic rr, output bit acc);
    bit   exp_rdy, exp_vld, pop;
    exp_t e;
    req_valid = v; req_wr_en = wr; req_addr = a; req_wr_data = wd;
    req_byte_en = be; req_is_signed = sg; rsp_ready = rr;
    #1;
    exp_rdy = exp_q.size() < MaxOut;
    exp_vld = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (exp_vld) begin
      check("rsp_rd_data", rsp_rd_data, exp_q[0].data);
      check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
    end
    acc = v && exp_rdy;
    pop = exp_vld && rr;
    @(posedge clk);
    cyc++;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      e     = model_req(wr, a, wd, be, sg);
      e.due = cyc + RdLat;
      exp_q.push_back(e);
    end
    #1;
  endtask

  // Holds a request until accepted, with rsp_ready fixed high.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic sg);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) step(1'b1, wr, a, wd, be, sg, 1'b1, acc);
    check("issue_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    bit          acc;
    int          issued;
    logic        v, wr, sg, rr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          lo, sel;

    rst_n = 1'b0; req_valid = 1'b0; req_wr_en = 1'b0; req_addr = '0; req_wr_data = '0;
    req_byte_en = 4'h0; req_is_signed = 1'b0; rsp_ready = 1'b0; cyc = 0;
    #2;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rd_data", rsp_rd_data, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(MemBytes / 4); i++) issue(1'b1, 32'(4 * i), $urandom, 4'hF, 1'b0);
    drain();

    // Store then immediate word load at address 0.
    issue(1'b1, 32'h0, 32'h0000_001E, 4'hF, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    drain();

    // Lane selection and extension.
    issue(1'b1, 32'h8, 32'h80FF_7F01, 4'hF, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'b0010, 1'b1);
    issue(1'b0, 32'h8, 32'h0, 4'b0010, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 4'b1100, 1'b1);
    issue(1'b0, 32'h8, 32'h0, 4'b0011, 1'b0);
    drain();

    // Fill to MaxOut with consumer stalled, then release it.
    issued = 0;
    for (int g = 0; g < 40 && issued < 6; g++) begin
      step(1'b1, 1'b0, 32'(4 * issued), '0, 4'hF, 1'b0, (g >= 8), acc);
      if (acc) issued++;
    end
    check("six_loads_accepted", 32'(issued), 32'd6);
    drain();

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(4 * i), '0, 4'hF, 1'b0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    drain();

    // Misaligned half store, then word load.
    issue(1'b1, 32'h1, 32'hAAAA_5555, 4'b0011, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
    drain();

    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1);
      sg  = $urandom_range(0, 1);
      rr  = ($urandom_range(0, 3) != 0);
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else if (sel == 1) a = MemBytes + 32'($urandom_range(0, 63));
      else               a = 32'($urandom_range(0, MemBytes - 1));
      if ($urandom_range(0, 1) == 1) begin
        be = legal_be[$urandom_range(0, 6)];
        lo = 0;
        while (lo < 3 && !be[lo]) lo++;
        a = {a[31:2], 2'(lo)};
      end else begin
        be = 4'($urandom_range(0, 15));
      end
      step(v, wr, a, wd, be, sg, rr, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
